// File: rtl/uib_dma_pkg.sv
// Shared constants for the uib DMA engine: bus geometry, slave map,
// access-mode encoding, register indices and the FSM state type.
package uib_dma_pkg;

  localparam int XLEN        = 32;
  localparam int SLAVE_WIDTH = 4;

  // uib address map (slave number = top SLAVE_WIDTH address bits)
  localparam logic [SLAVE_WIDTH-1:0] MAINMEM = 4'h0;
  localparam logic [SLAVE_WIDTH-1:0] UART    = 4'h1;
  localparam logic [SLAVE_WIDTH-1:0] TIMER   = 4'h2;
  localparam logic [SLAVE_WIDTH-1:0] DMA     = 4'h3;

  localparam logic [2:0] MODE_WORD = 3'b010;

  // register word indices (s_addr[4:2])
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } dma_state_t;

endpackage

// File: rtl/uib_dma_regs.sv
// Register file and slave handshake for the DMA engine. Holds the live
// SRC/DST pointers (advanced by the FSM), LEN, the interrupt enable and
// the W1C done flag, and produces start/abort strobes for the FSM.
module uib_dma_regs
  import uib_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_req,
  input  logic                        s_wen,
  input  logic [XLEN-SLAVE_WIDTH-1:0] s_addr,
  input  logic [2:0]                  s_mode,
  input  logic [XLEN-1:0]             s_dat_i,
  output logic [XLEN-1:0]             s_dat_o,
  output logic                        s_ready,
  input  logic                        busy,
  input  logic                        done_set,
  input  logic                        advance,
  output logic [XLEN-1:0]             src,
  output logic [XLEN-1:0]             dst,
  output logic [LEN_W-1:0]            len,
  output logic                        start_go,
  output logic                        abort_go,
  output logic                        intr
);

  logic [2:0]      idx;
  logic            acc;
  logic            wr;
  logic            ie;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            unused_addr;

  assign idx         = s_addr[4:2];
  assign unused_addr = ^{s_addr[XLEN-SLAVE_WIDTH-1:5], s_addr[1:0]};

  // A request is accepted only when no completion pulse is outstanding,
  // so a held s_req yields one access every two cycles.
  assign acc = s_req & ~s_ready;
  assign wr  = acc & s_wen & (s_mode == MODE_WORD);

  assign start_go = wr & (idx == REG_CTRL) & s_dat_i[0];
  assign abort_go = wr & (idx == REG_CTRL) & s_dat_i[2];

  // Read mux; start/abort are pulses and read back as 0
  always_comb begin
    rdata = '0;
    case (idx)
      REG_SRC:    rdata = src;
      REG_DST:    rdata = dst;
      REG_LEN:    rdata[LEN_W-1:0] = len;
      REG_CTRL:   rdata[1] = ie;
      REG_STATUS: rdata[1:0] = {done, busy};
      default:    rdata = '0;
    endcase
  end

  // Slave completion pulse and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready <= 1'b0;
      s_dat_o <= '0;
    end else begin
      s_ready <= acc;
      if (acc) s_dat_o <= rdata;
    end
  end

  // Transfer parameters: locked while busy, pointers advance per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else begin
      if (wr && !busy && idx == REG_SRC) src <= s_dat_i;
      else if (advance)                  src <= src + XLEN'(4);
      if (wr && !busy && idx == REG_DST) dst <= s_dat_i;
      else if (advance)                  dst <= dst + XLEN'(4);
      if (wr && !busy && idx == REG_LEN) len <= s_dat_i[LEN_W-1:0];
    end
  end

  // Interrupt enable, done flag (set beats W1C clear) and registered intr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie   <= 1'b0;
      done <= 1'b0;
      intr <= 1'b0;
    end else begin
      if (wr && idx == REG_CTRL) ie <= s_dat_i[1];
      if (done_set)                                      done <= 1'b1;
      else if (wr && idx == REG_STATUS && s_dat_i[1])    done <= 1'b0;
      intr <= done & ie;
    end
  end

endmodule

// File: rtl/uib_dma.sv
// Single-channel word-copy DMA. Reads one word from SRC, writes it to DST,
// repeats LEN times. Master outputs are registered and drop for one cycle
// between beats; an abort is only honoured after a completed write beat.
module uib_dma
  import uib_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_req,
  input  logic                        s_wen,
  input  logic [XLEN-SLAVE_WIDTH-1:0] s_addr,
  input  logic [2:0]                  s_mode,
  input  logic [XLEN-1:0]             s_dat_i,
  output logic [XLEN-1:0]             s_dat_o,
  output logic                        s_ready,
  output logic                        m_req,
  output logic                        m_wen,
  output logic [SLAVE_WIDTH-1:0]      m_num,
  output logic [XLEN-SLAVE_WIDTH-1:0] m_addr,
  output logic [2:0]                  m_mode,
  output logic [XLEN-1:0]             m_dat_o,
  input  logic [XLEN-1:0]             m_dat_i,
  input  logic                        m_ready,
  output logic                        intr
);

  dma_state_t       state, state_n;
  logic [XLEN-1:0]  src, dst, baddr, buffer;
  logic [LEN_W-1:0] len, count;
  logic             busy, beat, done_set, advance, abort_pend;
  logic             start_go, abort_go;

  assign busy   = (state != ST_IDLE);
  assign beat   = m_req & m_ready;
  assign baddr  = (state == ST_WR) ? dst : src;
  assign m_mode = MODE_WORD;

  uib_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .s_req    (s_req),
    .s_wen    (s_wen),
    .s_addr   (s_addr),
    .s_mode   (s_mode),
    .s_dat_i  (s_dat_i),
    .s_dat_o  (s_dat_o),
    .s_ready  (s_ready),
    .busy     (busy),
    .done_set (done_set),
    .advance  (advance),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .start_go (start_go),
    .abort_go (abort_go),
    .intr     (intr)
  );

  // Next-state logic and per-beat strobes
  always_comb begin
    state_n  = state;
    done_set = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_go) begin
          if (len != '0) state_n  = ST_RD;
          else           done_set = 1'b1;
        end
      end
      ST_RD: begin
        if (beat) state_n = ST_WR;
      end
      ST_WR: begin
        if (beat) begin
          advance = 1'b1;
          if (count == LEN_W'(1) || abort_pend) begin
            state_n  = ST_IDLE;
            done_set = 1'b1;
          end else begin
            state_n = ST_RD;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, working word counter and pending-abort flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start_go) count <= len;
      else if (advance)                 count <= count - LEN_W'(1);
      if (state == ST_IDLE)  abort_pend <= 1'b0;
      else if (abort_go)     abort_pend <= 1'b1;
    end
  end

  // Read data buffer between the read and write beats
  always_ff @(posedge clk) begin
    if (state == ST_RD && beat) buffer <= m_dat_i;
  end

  // Registered master request: launch when idle-on-bus, hold until m_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_wen   <= 1'b0;
      m_num   <= '0;
      m_addr  <= '0;
      m_dat_o <= '0;
    end else if (busy && !m_req) begin
      m_req   <= 1'b1;
      m_wen   <= (state == ST_WR);
      m_num   <= baddr[XLEN-1 -: SLAVE_WIDTH];
      m_addr  <= baddr[XLEN-SLAVE_WIDTH-1:0];
      m_dat_o <= buffer;
    end else if (beat) begin
      m_req <= 1'b0;
    end
  end

endmodule

// File: doc/uib_dma.md
# uib_dma

Single-channel word-copy DMA engine for the unisys SoC. It has two uib ports. The CPU programs it through a uib slave port. It moves data memory-to-memory, memory-to-UART or similar, through a uib master port that sits alongside the CPU on the bus. On completion it raises a level interrupt, which the SoC top ORs with the timer interrupt into the CPU `intr`.

## Interface
- `XLEN`, 32: bus data and address width (shared constant).
- `SLAVE_WIDTH`, 4: slave-select field width; address bits [XLEN-1 -: SLAVE_WIDTH] select the slave (shared constant).
- `LEN_W`, 16: transfer-length counter width, in words.
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock
  - `rst`  in  1  asynchronous, active-high reset
- Slave port (register access from the CPU):
  - `s_req`  in  1  access request
  - `s_wen`  in  1  1 = write
  - `s_addr`  in  XLEN-SLAVE_WIDTH  byte offset; bits [4:2] select the register
  - `s_mode`  in  3  access size; only word accesses (3'b010) are supported
  - `s_dat_i`  in  XLEN  write data
  - `s_dat_o`  out  XLEN  read data
  - `s_ready`  out  1  one-cycle completion pulse
- Master port (data movement):
  - `m_req`  out  1  bus request
  - `m_wen`  out  1  1 = write
  - `m_num`  out  SLAVE_WIDTH  target slave number
  - `m_addr`  out  XLEN-SLAVE_WIDTH  offset within the target slave
  - `m_mode`  out  3  always 3'b010 (word)
  - `m_dat_o`  out  XLEN  write data
  - `m_dat_i`  in  XLEN  read data
  - `m_ready`  in  1  beat complete
- Interrupt:
  - `intr`  out  1  equals done & ie

## Operation
- Registers (word index = `s_addr[4:2]`):
  - 0 SRC: source address.
  - 1 DST: destination address.
  - 2 LEN: word count, [LEN_W-1:0].
  - 3 CTRL: bit0 start (write-1 pulse, reads 0); bit1 ie; bit2 abort (write-1 pulse).
  - 4 STATUS: bit0 busy, bit1 done; write 1 to bit1 clears it.
  - Other indices read 0; writes to them are ignored.
- Writes to SRC, DST and LEN while busy are ignored. Reads while busy return the live, incrementing values.
- Address split: `m_num` = addr[XLEN-1 -: SLAVE_WIDTH]; `m_addr` = addr[XLEN-SLAVE_WIDTH-1:0]. SRC and DST increment by 4 with full XLEN wrap, so a carry can cross into another slave.
- FSM states: IDLE, RD, WR.
  - IDLE → RD: start with LEN≠0. Working counter loads from LEN; busy is set.
  - IDLE, start with LEN=0: done is set; no bus traffic occurs.
  - RD: `m_req`=1, `m_wen`=0, address from SRC. On `m_ready`, latch `m_dat_i` into the data buffer, then → WR.
  - WR: `m_req`=1, `m_wen`=1, address from DST, `m_dat_o` = buffer. On `m_ready`, SRC+=4, DST+=4 and count−=1. Go to IDLE with done set if the count was 1 or an abort is pending; otherwise go to RD.
  - Abort: sets a pending flag. The flag takes effect only at the end of a WR beat and is never honoured mid-handshake. Abort while in IDLE does nothing.
- Start while busy is ignored. A simultaneous done-set and W1C-clear resolves with the set winning.

## Timing
- Reset values: all registers 0; state IDLE; `m_req`=0, `m_wen`=0, `m_num`=0, `m_addr`=0, `m_dat_o`=0, `s_ready`=0, `s_dat_o`=0, `intr`=0.
- Master outputs are registered.
  - `m_req` rises the cycle after the state enters RD or WR.
  - `m_req`, `m_wen`, `m_num`, `m_addr` and `m_dat_o` stay stable until the cycle in which `m_ready`=1 is sampled.
  - When a beat completes and the next state is RD or WR, `m_req` drops for one cycle before the next beat. There is no back-to-back assertion.
- Minimum cost per word is 4 cycles with zero-wait slaves.
- Slave port:
  - `s_ready` pulses exactly one cycle after a sampled `s_req`.
  - `s_dat_o` is valid in the same cycle as that `s_ready` pulse.
  - The write takes effect in the cycle of the `s_ready` pulse.
  - `s_req` held high across cycles yields one access per two cycles.
- `intr` is registered; it updates one cycle after done or ie changes.
- Reset mid-transfer: the FSM returns to IDLE and `m_req` drops immediately (asynchronously). A partial beat is abandoned.

## Structure
- Shared package holds:
  - `XLEN`, `SLAVE_WIDTH` and the slave number `DMA`.
  - Mode encoding `MODE_WORD`=3'b010.
  - Register index constants.
  - The FSM state enum.
- The slave number `DMA` is allocated in the uib address map next to `MAINMEM`, `UART` and `TIMER`.
- One sub-module, `uib_dma_regs`: the register file, slave handshake and W1C logic. `uib_dma` holds the FSM and master port.

## Test plan
- Basic copy: SRC=MAINMEM+0x100, DST=MAINMEM+0x200, LEN=4, start → 4 read and 4 write beats. Destination words equal source 0x11,0x22,0x33,0x44. Busy falls and done=1; with ie=1, `intr`=1 one cycle later. W1C clears done and `intr`.
- LEN=0 start → no `m_req` activity; done=1 on the next cycle.
- Wait-state slave: `m_ready` delayed 5 cycles on every beat → request signals stay stable for all 5 cycles; data is correct; `m_req` drops for one cycle between beats.
- Abort asserted during the 2nd read of LEN=8 → that beat and its write finish; the FSM goes to IDLE; DST advanced by exactly 8; done=1.
- Programming while busy: write SRC=0xDEAD0000 mid-transfer → ignored; a readback shows the incrementing original value; a second start is ignored.
- Async reset during a WR beat → `m_req`=0 immediately; all registers read 0 afterwards; a new transfer then runs correctly.
